// File: rtl/register_write_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : register_write_arbiter_if
// Brief    : Requester/register-side bundle for the shared-register write
//            arbiter: level requests with flattened data in, one-hot
//            acknowledge, grant index and register in/load pins out.
// Revision : 1.0  initial release
// ============================================================================
interface register_write_arbiter_if #(
  parameter int WIDTH = 16,
  parameter int NREQ  = 4,
  parameter int IDW   = 2
);
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] wdata;
  logic [NREQ-1:0]       ack;
  logic [IDW-1:0]        grant_id;
  logic [WIDTH-1:0]      reg_in;
  logic                  reg_load;
  logic                  busy;

  // Requester / register side
  modport master (
    output req, wdata,
    input  ack, grant_id, reg_in, reg_load, busy
  );

  // Arbiter side
  modport slave (
    input  req, wdata,
    output ack, grant_id, reg_in, reg_load, busy
  );
endinterface
`default_nettype wire

// File: rtl/register_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : register_write_arbiter
// Brief    : Round-robin arbiter sharing write access to one WIDTH-bit
//            register among NREQ requesters. Drives the register's in/load
//            pins directly; one write per two cycles at most.
// Revision : 1.0  initial release
// ============================================================================
module register_write_arbiter #(
  parameter int WIDTH = 16,
  parameter int NREQ  = 4,
  parameter int IDW   = 2
) (
  input  wire                     clk,
  input  wire                     rst_n,
  register_write_arbiter_if.slave bus
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_LOAD = 1'b1
  } state_t;

  localparam logic [IDW-1:0] C_PTR_RESET = IDW'(NREQ - 1);

  state_t           r_state;
  logic [IDW-1:0]   r_ptr;
  logic [NREQ-1:0]  r_ack;
  logic [IDW-1:0]   r_grant_id;
  logic [WIDTH-1:0] r_reg_in;
  logic             r_reg_load;
  logic             r_busy;

  logic [IDW:0]     w_sum;
  logic [IDW-1:0]   w_winner;
  logic             w_found;
  logic [WIDTH-1:0] w_wdata_sel;
  logic [NREQ-1:0]  w_ack_onehot;

  // Circular search ptr+1 .. ptr+NREQ; walking offsets downwards lets the
  // nearest set request (smallest offset) overwrite any farther one.
  always_comb begin
    w_sum    = '0;
    w_winner = '0;
    w_found  = 1'b0;
    for (int off = NREQ; off >= 1; off--) begin
      w_sum = {1'b0, r_ptr} + (IDW+1)'(off);
      if (w_sum >= (IDW+1)'(NREQ)) begin
        w_sum = w_sum - (IDW+1)'(NREQ);
      end
      if (bus.req[w_sum[IDW-1:0]]) begin
        w_winner = w_sum[IDW-1:0];
        w_found  = 1'b1;
      end
    end
  end

  // Pure select of the winner's data slice; unselected slices never reach
  // reg_in, so X on them cannot leak through.
  always_comb begin
    w_wdata_sel  = '0;
    w_ack_onehot = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_winner == IDW'(i)) begin
        w_wdata_sel     = bus.wdata[i*WIDTH +: WIDTH];
        w_ack_onehot[i] = 1'b1;
      end
    end
  end

  // Two-state write FSM with registered outputs; async reset aborts a write
  // in flight (load drops immediately, no ack).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_ptr      <= C_PTR_RESET;
      r_ack      <= '0;
      r_grant_id <= '0;
      r_reg_in   <= '0;
      r_reg_load <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state    <= S_LOAD;
            r_ptr      <= w_winner;
            r_ack      <= w_ack_onehot;
            r_grant_id <= w_winner;
            r_reg_in   <= w_wdata_sel;
            r_reg_load <= 1'b1;
            r_busy     <= 1'b1;
          end
        end
        S_LOAD: begin
          // Register captures reg_in at this edge; reg_in/grant_id hold.
          r_state    <= S_IDLE;
          r_ack      <= '0;
          r_reg_load <= 1'b0;
          r_busy     <= 1'b0;
        end
        default: begin
          r_state    <= S_IDLE;
          r_ack      <= '0;
          r_reg_load <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ack      = r_ack;
  assign bus.grant_id = r_grant_id;
  assign bus.reg_in   = r_reg_in;
  assign bus.reg_load = r_reg_load;
  assign bus.busy     = r_busy;

endmodule
`default_nettype wire
